// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data memory responder: one request at a time over
// valid/ready, fixed access latency, 1/2/4/8-byte loads and stores with error flag.
`timescale 1ns/1ps

module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | latency countdown; access commits on the edge where cnt==0
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [3:0]  lat_size;

  logic [7:0]           mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] byte_idx [8];
  logic [63:0]          rd_data;
  logic [ADDR_BITS:0]   end_addr;
  logic                 size_ok;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 acc_err;
  logic                 commit_we;

  assign req_ready = reset && (state == IDLE);
  assign busy      = (state != IDLE);

  assign size_ok      = (lat_size == 4'd1) || (lat_size == 4'd2) ||
                        (lat_size == 4'd4) || (lat_size == 4'd8);
  assign misaligned   = |(lat_addr[3:0] & (lat_size - 4'd1));
  assign end_addr     = {1'b0, lat_addr[ADDR_BITS-1:0]} + (ADDR_BITS+1)'(lat_size);
  assign out_of_range = (|lat_addr[63:ADDR_BITS]) ||
                        (end_addr > {1'b1, {ADDR_BITS{1'b0}}});
  assign acc_err      = !size_ok || misaligned || out_of_range;
  assign commit_we    = (state == WAIT) && (cnt == 4'd0) && lat_write && !acc_err;

  // Byte i of the value (LSB = 0) lives at addr+size-1-i: big-endian layout.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      byte_idx[i] = lat_addr[ADDR_BITS-1:0] + ADDR_BITS'(lat_size) - ADDR_BITS'(i + 1);
      if (i < int'(lat_size))
        rd_data[8*i +: 8] = mem[byte_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (commit_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(lat_size))
          mem[byte_idx[i]] <= lat_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_size  <= req_size;
            cnt       <= 4'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || lat_write) ? 64'd0 : rd_data;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
